// File: rtl/perf_counter_unit_pkg.sv
// Shared definitions for the performance-monitor block.
// Holds the core geometry (threads, ALU lanes, field widths), the counter
// address map used by the shadow read port, and the ALU op-code constants
// that classify a dispatched lane as an instruction and/or a taken branch.
package perf_counter_unit_pkg;

    localparam int NUM_THREADS = 4;
    localparam int NUM_ALUS    = 4;
    localparam int TID_W       = 3;
    localparam int OH_W        = 7;
    localparam int CNT_W       = 32;
    localparam int ADDR_W      = 4;

    // Per-thread increment can reach NUM_ALUS when every lane carries one thread.
    localparam int INC_W   = $clog2(NUM_ALUS + 1);
    // Cycle counter plus an instruction and a branch counter per thread.
    localparam int NUM_CNT = 2 * NUM_THREADS + 1;

    // Address map; the counter index equals its read address and its
    // bit position in the overflow vector.
    localparam int PERF_ADDR_CYCLES    = 0;
    localparam int PERF_ADDR_INST_BASE = 1;
    localparam int PERF_ADDR_BR_BASE   = 2;
    localparam int PERF_ADDR_STRIDE    = 2;
    localparam int PERF_ADDR_OVF       = 9;

    localparam logic [OH_W-1:0] OH_NOP   = 7'd0;
    localparam logic [OH_W-1:0] OH_JAL   = 7'd3;
    localparam logic [OH_W-1:0] OH_JALR  = 7'd4;
    localparam logic [OH_W-1:0] OH_BR_LO = 7'd5;
    localparam logic [OH_W-1:0] OH_BR_HI = 7'd10;

    typedef logic [CNT_W-1:0] cnt_t;

    // jal/jalr always redirect; conditional branches only when the condition held.
    function automatic logic is_taken_br(input logic [OH_W-1:0] oh, input logic jump_en);
        return (oh == OH_JAL) || (oh == OH_JALR) ||
               ((oh >= OH_BR_LO) && (oh <= OH_BR_HI) && jump_en);
    endfunction

endpackage

// File: rtl/perf_counter_unit_sat_counter.sv
// Saturating event counter with a sticky overflow flag.
// Ports:
//   clk, rst      clock and synchronous active-low reset
//   clear_i       zero count and overflow flag (beats freeze_i)
//   freeze_i      hold the count
//   inc_i         amount to add this cycle
//   count_o       current count, never wraps
//   ovf_o         set once an increment would have exceeded the maximum
module perf_sat_counter #(
    parameter int CNT_W = 32,
    parameter int INC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             freeze_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W:0]   sat_res;

    // Returns {overflowed, saturated sum}.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        if (sum[CNT_W]) begin
            return {1'b1, {CNT_W{1'b1}}};
        end
        return sum;
    endfunction

    always_comb begin
        sat_res = sat_add(cnt_q, inc_i);
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (!freeze_i) begin
            cnt_d = sat_res[CNT_W-1:0];
            ovf_d = ovf_q | sat_res[CNT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Performance monitor downstream of EX dispatch.
// Counts cycles plus per-thread retired instructions and taken branches,
// snapshots them atomically into shadow registers and serves the shadows
// through a one-cycle-latency read port.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   lane_tid/lane_oh/lane_jump_en  per-lane dispatch observation
//   freeze, clear, snap            live-counter control
//   rd_req, rd_addr                shadow read request
//   rd_valid, rd_data              registered read response
//   ovf                            OR of live sticky overflow flags
module perf_counter_unit
    import perf_counter_unit_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_ALUS-1:0][TID_W-1:0] lane_tid,
    input  logic [NUM_ALUS-1:0][OH_W-1:0]  lane_oh,
    input  logic [NUM_ALUS-1:0]            lane_jump_en,
    input  logic                           freeze,
    input  logic                           clear,
    input  logic                           snap,
    input  logic                           rd_req,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic                           rd_valid,
    output logic [CNT_W-1:0]               rd_data,
    output logic                           ovf
);

    logic [INC_W-1:0] inst_inc [NUM_THREADS];
    logic [INC_W-1:0] br_inc   [NUM_THREADS];
    cnt_t             live_cnt [NUM_CNT];
    logic [NUM_CNT-1:0] live_ovf;
    cnt_t             shadow_q [NUM_CNT];
    logic [NUM_CNT-1:0] shadow_ovf_q;
    cnt_t             rd_word;
    logic             rd_valid_q;
    cnt_t             rd_data_q;

    // A bubble tid (>= NUM_THREADS) never matches any thread index.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            inst_inc[t] = '0;
            br_inc[t]   = '0;
        end
        for (int t = 0; t < NUM_THREADS; t++) begin
            for (int a = 0; a < NUM_ALUS; a++) begin
                if (lane_tid[a] == TID_W'(t)) begin
                    if (lane_oh[a] != OH_NOP) begin
                        inst_inc[t] = inst_inc[t] + INC_W'(1);
                    end
                    if (is_taken_br(lane_oh[a], lane_jump_en[a])) begin
                        br_inc[t] = br_inc[t] + INC_W'(1);
                    end
                end
            end
        end
    end

    perf_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cyc (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (clear),
        .freeze_i (freeze),
        .inc_i    (1'b1),
        .count_o  (live_cnt[PERF_ADDR_CYCLES]),
        .ovf_o    (live_ovf[PERF_ADDR_CYCLES])
    );

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        perf_sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_inst (
            .clk      (clk),
            .rst      (rst),
            .clear_i  (clear),
            .freeze_i (freeze),
            .inc_i    (inst_inc[t]),
            .count_o  (live_cnt[PERF_ADDR_INST_BASE + PERF_ADDR_STRIDE*t]),
            .ovf_o    (live_ovf[PERF_ADDR_INST_BASE + PERF_ADDR_STRIDE*t])
        );
        perf_sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_br (
            .clk      (clk),
            .rst      (rst),
            .clear_i  (clear),
            .freeze_i (freeze),
            .inc_i    (br_inc[t]),
            .count_o  (live_cnt[PERF_ADDR_BR_BASE + PERF_ADDR_STRIDE*t]),
            .ovf_o    (live_ovf[PERF_ADDR_BR_BASE + PERF_ADDR_STRIDE*t])
        );
    end

    // Shadows sample the register outputs, i.e. the values before this
    // cycle's update, so a snap alongside clear keeps the pre-clear counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow_q[i] <= '0;
            end
            shadow_ovf_q <= '0;
        end else if (snap) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow_q[i] <= live_cnt[i];
            end
            shadow_ovf_q <= live_ovf;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_word = shadow_q[i];
            end
        end
        if (rd_addr == ADDR_W'(PERF_ADDR_OVF)) begin
            rd_word = CNT_W'(shadow_ovf_q);
        end
    end

    // Reading the old shadow here gives a same-cycle snap+read the previous value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign ovf      = |live_ovf;

endmodule

// File: tb/tb_perf_counter_unit.sv
module tb_perf_counter_unit;
    import perf_counter_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           rst;
    logic [NUM_ALUS-1:0][TID_W-1:0] lane_tid;
    logic [NUM_ALUS-1:0][OH_W-1:0]  lane_oh;
    logic [NUM_ALUS-1:0]            lane_jump_en;
    logic                           freeze, clear, snap, rd_req;
    logic [ADDR_W-1:0]              rd_addr;
    logic                           rd_valid;
    logic [CNT_W-1:0]               rd_data;
    logic                           ovf;

    perf_counter_unit dut (
        .clk          (clk),
        .rst          (rst),
        .lane_tid     (lane_tid),
        .lane_oh      (lane_oh),
        .lane_jump_en (lane_jump_en),
        .freeze       (freeze),
        .clear        (clear),
        .snap         (snap),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .ovf          (ovf)
    );

    typedef struct {
        logic [CNT_W-1:0] data;
        int               addr;
        int               due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   tb_cyc = 0;
    logic [CNT_W-1:0] model_cyc = '0;

    // Reference cycle count, used only where the run length makes hand counting awkward.
    always @(posedge clk) begin
        tb_cyc <= tb_cyc + 1;
        if (!rst || clear) model_cyc <= '0;
        else if (!freeze)  model_cyc <= model_cyc + 1;
    end

    task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pops the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_spurious: rd_valid=1 data 0x%08h, expected no response", rd_data);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("rd_data[addr %0d]", mon_e.addr), rd_data, mon_e.data);
                check($sformatf("rd_cycle[addr %0d]", mon_e.addr), tb_cyc, mon_e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= tb_cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_missing[addr %0d]: rd_valid=0 at cycle %0d, expected 1 at cycle %0d",
                     sb[0].addr, tb_cyc, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic rd(input int a, input logic [CNT_W-1:0] exp);
        exp_t e;
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(a);
        e.data  = exp;
        e.addr  = a;
        e.due   = tb_cyc + 1;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic rd_stop();
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_lane(input int a, input int tid, input int oh, input bit je);
        lane_tid[a]     = TID_W'(tid);
        lane_oh[a]      = OH_W'(oh);
        lane_jump_en[a] = je;
    endtask

    task automatic idle();
        for (int a = 0; a < NUM_ALUS; a++) set_lane(a, NUM_THREADS, 0, 1'b0);
    endtask

    task automatic do_snap();
        snap = 1'b1;
        @(negedge clk);
        snap = 1'b0;
    endtask

    logic [CNT_W-1:0] exp_tab [12];
    logic [CNT_W-1:0] cyc_at_snap;

    initial begin
        rst = 1'b0; freeze = 1'b0; clear = 1'b0; snap = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        idle();
        repeat (3) @(negedge clk);
        check("reset_rd_valid", 32'(rd_valid), 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_ovf", 32'(ovf), 0);

        // Ten idle cycles after reset release.
        rst = 1'b1;
        repeat (10) @(negedge clk);
        do_snap();
        rd(0, 32'd10);
        rd(1, 32'd0);
        rd_stop();

        // tid 2 on all lanes, five cycles.
        for (int a = 0; a < NUM_ALUS; a++) set_lane(a, 2, 1, 1'b0);
        repeat (5) @(negedge clk);
        idle();
        do_snap();
        rd(5, 32'd20);
        rd(6, 32'd0);
        rd(1, 32'd0);
        rd(3, 32'd0);
        rd(7, 32'd0);
        rd_stop();

        // Branch mix on thread 1 in one cycle.
        set_lane(0, 1, 7, 1'b1);
        set_lane(1, 1, 7, 1'b0);
        set_lane(2, 1, 3, 1'b0);
        @(negedge clk);
        idle();
        do_snap();
        rd(4, 32'd2);
        rd(3, 32'd3);
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rd_valid_pulse", 32'(rd_valid), 0);
        check("rd_data_hold", rd_data, 32'd3);
        rd_stop();

        // Saturation of thread 0 instruction counter.
        check("ovf_before_sat", 32'(ovf), 0);
        force dut.g_thr[0].u_inst.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.g_thr[0].u_inst.cnt_q;
        for (int a = 0; a < NUM_ALUS; a++) set_lane(a, 0, 1, 1'b0);
        @(negedge clk);
        idle();
        check("ovf_after_sat", 32'(ovf), 1);
        do_snap();
        rd(1, 32'hFFFF_FFFF);
        rd(9, 32'h0000_0002);
        rd(2, 32'd0);
        rd_stop();
        check("ovf_sticky", 32'(ovf), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("ovf_after_clear", 32'(ovf), 0);

        // Six instructions on thread 3, then frozen traffic.
        set_lane(0, 3, 1, 1'b0);
        set_lane(1, 3, 1, 1'b0);
        repeat (3) @(negedge clk);
        freeze = 1'b1;
        for (int a = 0; a < NUM_ALUS; a++) set_lane(a, 3, 5, 1'b1);
        repeat (6) @(negedge clk);
        // clear under freeze, with snap; this cycle's traffic is discarded.
        clear = 1'b1;
        snap  = 1'b1;
        @(negedge clk);
        clear = 1'b0; snap = 1'b0; freeze = 1'b0;
        idle();
        rd(8, 32'd0);
        snap = 1'b1;
        rd(7, 32'd6);
        snap = 1'b0;
        rd(7, 32'd0);
        rd(0, 32'd1);
        rd(9, 32'd0);
        rd_stop();

        // Mixed lanes incl. jalr, oh=10 boundary, bubbles, nop and oh=11.
        set_lane(0, 0, 4, 1'b0);
        set_lane(1, 1, 1, 1'b0);
        set_lane(2, 2, 6, 1'b1);
        set_lane(3, 3, 10, 1'b1);
        @(negedge clk);
        set_lane(0, 4, 1, 1'b1);
        set_lane(1, 7, 3, 1'b0);
        set_lane(2, 1, 0, 1'b1);
        set_lane(3, 3, 11, 1'b1);
        @(negedge clk);
        idle();
        cyc_at_snap = model_cyc;
        do_snap();
        exp_tab = '{cyc_at_snap, 32'd1, 32'd1, 32'd1, 32'd0, 32'd1, 32'd1,
                    32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 12; i++) rd(i, exp_tab[i]);
        rd_stop();

        // Reset together with a read request: no response.
        rst     = 1'b0;
        rd_req  = 1'b1;
        rd_addr = '0;
        @(negedge clk);
        rd_req = 1'b0;
        check("rst_cancel_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ovf", 32'(ovf), 0);
        @(negedge clk);
        rst = 1'b1;
        rd(7, 32'd0);
        rd(5, 32'd0);
        rd_stop();

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Hardware performance-monitor block in the 4-thread / 4-ALU core.
- Sits directly downstream of the EX dispatch stage. Each cycle it consumes, per ALU lane, the dispatched thread id, the op code sent to the ALU, and the jump-enable result.
- Keeps per-thread retired-instruction and taken-branch counters plus a global cycle counter.
- Exposes the counts through an atomic snapshot plus a registered read port, so IPC and branch rate are measurable in silicon, not only in simulation.

Parameters:
- NUM_THREADS, 4, number of hardware threads; valid thread ids are 0..NUM_THREADS-1.
- NUM_ALUS, 4, number of ALU lanes observed per cycle.
- TID_W, 3, width of a lane thread id; a value >= NUM_THREADS marks a bubble.
- OH_W, 7, width of the ALU op code per lane.
- CNT_W, 32, width of every counter.
- ADDR_W, 4, read address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- lane_tid  in  NUM_ALUS x TID_W  thread id dispatched on each lane this cycle.
- lane_oh  in  NUM_ALUS x OH_W  ALU op code per lane; 0 = no-op.
- lane_jump_en  in  NUM_ALUS x 1  branch-condition-true per lane.
- freeze  in  1  level; hold all live counters.
- clear  in  1  pulse; zero all live counters and overflow flags.
- snap  in  1  pulse; copy live counters and flags into shadow registers.
- rd_req  in  1  read request pulse.
- rd_addr  in  ADDR_W  shadow register select.
- rd_valid  out  1  read data valid.
- rd_data  out  CNT_W  read data.
- ovf  out  1  OR of all sticky overflow flags (live).

Behaviour:
- Reset (rst=0 at posedge): all live counters, shadow registers and flags clear to 0; rd_valid=0, rd_data=0, ovf=0.
- Lane counts as an instruction when lane_tid < NUM_THREADS and lane_oh != 0.
- Lane counts as a taken branch when lane_tid < NUM_THREADS and either:
  - lane_oh is in 5..10 with lane_jump_en=1, or
  - lane_oh is 3 or 4 (jal/jalr), regardless of lane_jump_en.
- Per thread t, each cycle:
  - inst_inc[t] = number of lanes with tid==t that count as an instruction; range 0..NUM_ALUS, width clog2(NUM_ALUS+1).
  - br_inc[t] = number of lanes with tid==t that count as a taken branch; same range and width.
  - Several lanes carrying the same thread in one cycle all count.
- cyc_cnt increments by 1 every cycle, after rst has been released, in which freeze=0 and clear=0.
- Counters saturate at 2^CNT_W-1 and never wrap.
  - An increment that would exceed the maximum sets that counter's sticky overflow flag.
  - Overflow flags clear only on clear or reset.
- Priority, highest first: reset > clear > freeze > increment.
  - clear with freeze=1 still zeroes the counters.
  - Inputs in the cycle carrying clear are discarded.
- Snap takes 1 cycle.
  - On snap, the shadows capture the live values as they stand before this cycle's update.
  - snap together with clear therefore captures the pre-clear values.
  - snap has no effect on the live counters.
- Read latency is 1 cycle.
  - rd_req=1 at edge N gives rd_valid=1 and rd_data at edge N+1; rd_valid is a single-cycle pulse per request.
  - Back-to-back requests are allowed, one per cycle.
  - rd_data holds its value when rd_valid=0.
- Address map (all addresses read shadow registers):
  - 0 = cycles.
  - 1+2t = instructions of thread t.
  - 2+2t = taken branches of thread t.
  - 9 = overflow flag vector, zero-extended; bit 0 = cycles, bit 1+2t = instructions of thread t, bit 2+2t = branches of thread t.
  - Any other address returns 0 with rd_valid=1.
- rd_req in the same cycle as snap returns the previous shadow value; the new snapshot is visible from the next request.
- Reset mid-read: a pending rd_valid is cancelled.

Decomposition:
- Shared package types:
  - NUM_THREADS and NUM_ALUs (already present).
  - PERF_ADDR_* localparams for the address map.
  - Op-code constants: OH_JAL=3, OH_JALR=4, OH_BR_LO=5, OH_BR_HI=10.
- One sub-module: perf_sat_counter, parameterised by CNT_W and INC_W.
  - Inputs: clear, freeze, inc.
  - Outputs: count, sticky ovf.
  - Instanced 2*NUM_THREADS+1 times.

Test Plan:
- Reset, then 10 idle cycles (all tids=4), snap, read addr 0 and addr 1 -> cycles=10, instructions=0.
- Dispatch tid=2 with oh=1 on all 4 lanes for 5 cycles, snap, read addr 5 -> 20; read addr 1/3/7 -> 0.
- Same cycle, lane0 tid1 oh=7 jump_en=1, lane1 tid1 oh=7 jump_en=0, lane2 tid1 oh=3 jump_en=0, snap next cycle, read addr 4 -> 2 and addr 3 -> 3.
- Force-preload thread0 instruction counter to 2^32-2, dispatch 4 lanes tid0 -> counter 2^32-1, ovf=1, address 9 bit 1 set; then clear -> ovf=0.
- freeze=1 for 6 cycles with traffic -> counters unchanged; snap and clear in the same cycle -> shadow holds pre-clear values and live counters are 0.
- rd_req every cycle over addresses 0..11 -> rd_valid is high for 12 consecutive cycles, each one cycle late; addresses 10 and 11 return 0.
